// File: rtl/bcd_ex3_seq_ctrl.sv
// Sequential BCD to Excess-3 converter: accepts a packed BCD word, converts one
// digit per clock through a single shared +3 adder, and holds the result until retired.
module bcd_ex3_seq_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   ex3_out,
   output logic [DIGITS-1:0]     err_mask,
   output logic                  busy
);

   localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [4*DIGITS-1:0]   word_q, word_d;
   logic [4*DIGITS-1:0]   ex3_q, ex3_d;
   logic [DIGITS-1:0]     err_q, err_d;

   logic [3:0]            digit;
   logic [3:0]            digit_ex3;
   logic                  digit_err;

   // Digit selected by the counter feeds the one shared converter.
   always_comb begin
      digit = 4'd0;
      for (int k = 0; k < DIGITS; k++) begin
         if (cnt_q == CW'(k)) begin
            digit = word_q[4*k +: 4];
         end
      end
   end

   always_comb begin
      digit_err = (digit > 4'd9);
      digit_ex3 = digit + 4'd3;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      ex3_d   = ex3_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = CONV;
               word_d  = bcd_in;
               cnt_d   = '0;
               ex3_d   = '0;
               err_d   = '0;
            end
         end
         CONV: begin
            for (int k = 0; k < DIGITS; k++) begin
               if (cnt_q == CW'(k)) begin
                  ex3_d[4*k +: 4] = digit_err ? 4'd0 : digit_ex3;
                  err_d[k]        = digit_err;
               end
            end
            // Counter parks on the last digit rather than wrapping.
            if (cnt_q == LAST) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         word_q  <= '0;
         ex3_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         ex3_q   <= ex3_d;
         err_q   <= err_d;
      end
   end

   // Results are only exposed while presented; they read zero otherwise.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign ex3_out   = out_valid ? ex3_q : '0;
   assign err_mask  = out_valid ? err_q : '0;

endmodule

// File: tb/tb_bcd_ex3_seq_ctrl.sv
// Self-checking bench for bcd_ex3_seq_ctrl: a 4-digit build driven by directed and
// random words against a digit-by-digit arithmetic model, plus a 1-digit build.
module tb_bcd_ex3_seq_ctrl;

   logic        clk;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, busy;
   logic [15:0] bcd_in, ex3_out;
   logic [3:0]  err_mask;

   logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
   logic [3:0]  bcd_in1, ex3_out1;
   logic [0:0]  err_mask1;

   int total = 0;
   int bad   = 0;

   bcd_ex3_seq_ctrl #(.DIGITS(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .bcd_in(bcd_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .ex3_out(ex3_out), .err_mask(err_mask), .busy(busy)
   );

   bcd_ex3_seq_ctrl #(.DIGITS(1)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid1), .in_ready(in_ready1), .bcd_in(bcd_in1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .ex3_out(ex3_out1), .err_mask(err_mask1), .busy(busy1)
   );

   always #5 clk = ~clk;

   // Reference: each nibble above 9 becomes 0 with its error bit set, otherwise nibble+3.
   function automatic void ref_conv(input logic [15:0] w, output logic [15:0] e, output logic [3:0] m);
      int d;
      e = '0;
      m = '0;
      for (int k = 0; k < 4; k++) begin
         d = int'((w >> (4*k)) & 16'hF);
         if (d > 9) m[k] = 1'b1;
         else       e = e | 16'((d + 3) << (4*k));
      end
   endfunction

   function automatic logic [15:0] rand_word();
      logic [15:0] w;
      w = '0;
      for (int k = 0; k < 4; k++) begin
         if ($urandom % 4 == 0) w = w | 16'($urandom_range(10, 15) << (4*k));
         else                   w = w | 16'($urandom_range(0, 9) << (4*k));
      end
      return w;
   endfunction

   task automatic send(input logic [15:0] w);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!in_ready) begin
         bad++;
         $display("[TB] FAIL send_ready_timeout in_ready=%b required=1", in_ready);
      end
      in_valid = 1'b1;
      bcd_in   = w;
      @(negedge clk);
      in_valid = 1'b0;
      bcd_in   = 16'($urandom);
   endtask

   task automatic wait_out(output int lat, output bit saw_ready);
      lat       = 0;
      saw_ready = 1'b0;
      while (!out_valid && lat < 20) begin
         if (in_ready) saw_ready = 1'b1;
         in_valid = 1'($urandom % 2);
         bcd_in   = 16'($urandom);
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      total++;
      if (!out_valid) begin
         bad++;
         $display("[TB] FAIL out_valid_timeout out_valid=%b required=1", out_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({in_ready, out_valid, busy, ex3_out, err_mask} !== {1'b1, 1'b0, 1'b0, 16'h0, 4'h0}) begin
         bad++;
         $display("[TB] FAIL reset_state rdy=%b vld=%b busy=%b ex3=%h err=%b required 1 0 0 0000 0000",
                  in_ready, out_valid, busy, ex3_out, err_mask);
      end
      total++;
      if ({in_ready1, out_valid1, busy1, ex3_out1, err_mask1} !== {1'b1, 1'b0, 1'b0, 4'h0, 1'b0}) begin
         bad++;
         $display("[TB] FAIL reset_state_d1 rdy=%b vld=%b busy=%b ex3=%h err=%b required 1 0 0 0 0",
                  in_ready1, out_valid1, busy1, ex3_out1, err_mask1);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_result(input string name, input logic [15:0] w);
      logic [15:0] e;
      logic [3:0]  m;
      ref_conv(w, e, m);
      total++;
      if (ex3_out !== e || err_mask !== m) begin
         bad++;
         $display("[TB] FAIL %s word=%h ex3=%h err=%b required ex3=%h err=%b", name, w, ex3_out, err_mask, e, m);
      end
   endtask

   task automatic test_nominal();
      int lat;
      bit sr;
      out_ready = 1'b1;
      send(16'h1234);
      wait_out(lat, sr);
      total++;
      if (lat != 4) begin
         bad++;
         $display("[TB] FAIL nominal_latency got=%0d required=4", lat);
      end
      total++;
      if (sr) begin
         bad++;
         $display("[TB] FAIL nominal_in_ready_during_conv got=1 required=0");
      end
      check_result("nominal_result", 16'h1234);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL nominal_one_cycle vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_full_range();
      logic [15:0] words [3];
      int lat;
      bit sr;
      words[0] = 16'h0000;
      words[1] = 16'h9999;
      words[2] = 16'h5050;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send(words[i]);
         wait_out(lat, sr);
         total++;
         if (sr || lat != 4) begin
            bad++;
            $display("[TB] FAIL full_range_window word=%h saw_ready=%b lat=%0d required 0 4", words[i], sr, lat);
         end
         check_result("full_range_result", words[i]);
      end
      @(negedge clk);
   endtask

   task automatic test_invalid();
      int lat;
      bit sr;
      out_ready = 1'b1;
      send(16'h12A4);
      wait_out(lat, sr);
      check_result("invalid_one_digit", 16'h12A4);
      send(16'hFFFF);
      wait_out(lat, sr);
      check_result("invalid_all_digits", 16'hFFFF);
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int lat;
      bit sr;
      out_ready = 1'b0;
      send(16'h1234);
      wait_out(lat, sr);
      for (int i = 0; i < 5; i++) begin
         total++;
         if (ex3_out !== 16'h4567 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL backpressure_hold cyc=%0d ex3=%h rdy=%b vld=%b required 4567 0 1",
                     i, ex3_out, in_ready, out_valid);
         end
         in_valid = 1'b1;
         bcd_in   = 16'($urandom);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL backpressure_release vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
      end
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL backpressure_no_latch busy=%b vld=%b required 0 0", busy, out_valid);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      bit sr;
      out_ready = 1'b1;
      send(16'h1234);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if ({in_ready, out_valid, busy, ex3_out, err_mask} !== {1'b1, 1'b0, 1'b0, 16'h0, 4'h0}) begin
         bad++;
         $display("[TB] FAIL reset_mid_state rdy=%b vld=%b busy=%b ex3=%h err=%b required 1 0 0 0000 0000",
                  in_ready, out_valid, busy, ex3_out, err_mask);
      end
      repeat (5) @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_mid_discard vld=%b required=0", out_valid);
      end
      send(16'h0007);
      wait_out(lat, sr);
      check_result("reset_mid_new_word", 16'h0007);
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [15:0] w;
      int lat, stall;
      bit sr;
      for (int i = 0; i < 30; i++) begin
         w = rand_word();
         out_ready = 1'($urandom % 2);
         send(w);
         wait_out(lat, sr);
         total++;
         if (lat != 4 || sr) begin
            bad++;
            $display("[TB] FAIL random_timing word=%h lat=%0d saw_ready=%b required 4 0", w, lat, sr);
         end
         check_result("random_result", w);
         if (!out_ready) begin
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
               bcd_in = 16'($urandom);
               @(negedge clk);
               check_result("random_stall_hold", w);
            end
            out_ready = 1'b1;
         end
         @(negedge clk);
         total++;
         if (out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL random_retire vld=%b required=0", out_valid);
         end
      end
   endtask

   task automatic test_digits1();
      logic [3:0] vals [3];
      logic [3:0] d, e;
      logic       m;
      vals[0] = 4'h8;
      vals[1] = 4'hC;
      vals[2] = 4'($urandom);
      out_ready1 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         d = vals[i];
         m = (d > 9);
         e = m ? 4'h0 : 4'(d + 3);
         in_valid1 = 1'b1;
         bcd_in1   = d;
         @(negedge clk);
         in_valid1 = 1'b0;
         bcd_in1   = 4'($urandom);
         total++;
         if (out_valid1 !== 1'b0 || busy1 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL d1_conv vld=%b busy=%b required 0 1", out_valid1, busy1);
         end
         @(negedge clk);
         total++;
         if (out_valid1 !== 1'b1 || ex3_out1 !== e || err_mask1 !== m) begin
            bad++;
            $display("[TB] FAIL d1_result in=%h vld=%b ex3=%h err=%b required 1 %h %b",
                     d, out_valid1, ex3_out1, err_mask1, e, m);
         end
         @(negedge clk);
         total++;
         if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL d1_retire vld=%b rdy=%b required 0 1", out_valid1, in_ready1);
         end
      end
   endtask

   initial begin
      clk        = 1'b0;
      rst        = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      bcd_in     = '0;
      in_valid1  = 1'b0;
      out_ready1 = 1'b0;
      bcd_in1    = '0;
      test_reset();
      test_nominal();
      test_full_range();
      test_invalid();
      test_backpressure();
      test_reset_mid();
      test_random();
      test_digits1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
